// File: rtl/two_sum_ctrl.sv
// two_sum_ctrl: streaming two-sum controller in front of a direct-mapped hashmap.
//
// For each accepted element the complement (target - element) is looked up in
// the hashmap. On a miss the element is inserted as key=element,
// value={element, index}. The stored element copy lets a hit be confirmed
// against the looked-up key, so a slot that holds a different key is never
// reported as a pair. The result is presented once the last element has been
// consumed.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, target     begin a problem (sampled only in idle), target sum
//   busy              high in every state except idle
//   in_valid/ready    element stream handshake; in_data element, in_last final
//   out_valid/ready   result handshake; out_valid is held until out_ready
//   out_found         a pair was found; out_index0/1 earlier/later index
//   out_overflow      stream was longer than 2**INDEX_WIDTH elements
//   hm_*              hashmap write/read/clear ports (read is combinational)

module two_sum_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [DATA_WIDTH-1:0]             target,
    output logic                              busy,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              out_found,
    output logic [INDEX_WIDTH-1:0]            out_index0,
    output logic [INDEX_WIDTH-1:0]            out_index1,
    output logic                              out_overflow,
    output logic [DATA_WIDTH-1:0]             hm_write_key,
    output logic [DATA_WIDTH+INDEX_WIDTH-1:0] hm_write_value,
    output logic                              hm_write_request,
    output logic [DATA_WIDTH-1:0]             hm_read_key,
    input  logic [DATA_WIDTH+INDEX_WIDTH-1:0] hm_read_value,
    input  logic                              hm_read_response,
    output logic                              hm_clear
);

    localparam int VALUE_WIDTH = DATA_WIDTH + INDEX_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StRun,
        StDone
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  target_q;
    // One extra bit so the counter can sit at 2**INDEX_WIDTH and flag overflow.
    logic [INDEX_WIDTH:0]   index_q;
    logic                   found_q;
    logic                   overflow_q;
    logic [INDEX_WIDTH-1:0] index0_q;
    logic [INDEX_WIDTH-1:0] index1_q;

    logic accept;
    logic in_window;
    logic hit;
    logic search;

    // Datapath toward the hashmap.
    always_comb begin
        accept      = (state_q == StRun) && in_valid;
        in_window   = !index_q[INDEX_WIDTH];
        hm_read_key = target_q - in_data;  // wraps modulo 2**DATA_WIDTH
        hit         = hm_read_response &&
                      (hm_read_value[VALUE_WIDTH-1 -: DATA_WIDTH] == hm_read_key);
        search      = accept && !found_q && in_window;
        // Lookup uses this cycle's read; the insert lands at the clock edge, so
        // an element can never match itself.
        hm_write_request = search && !hit;
        hm_write_key     = in_data;
        hm_write_value   = {in_data, index_q[INDEX_WIDTH-1:0]};
    end

    // Next-state and status outputs.
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != StIdle);
        in_ready  = (state_q == StRun);
        out_valid = (state_q == StDone);
        hm_clear  = (state_q == StClear);
        unique case (state_q)
            StIdle:  if (start) state_d = StClear;
            StClear: state_d = StRun;
            StRun:   if (accept && in_last) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target_q   <= '0;
            index_q    <= '0;
            found_q    <= 1'b0;
            overflow_q <= 1'b0;
            index0_q   <= '0;
            index1_q   <= '0;
        end else begin
            if (state_q == StIdle && start) begin
                target_q   <= target;
                index_q    <= '0;
                found_q    <= 1'b0;
                overflow_q <= 1'b0;
                index0_q   <= '0;
                index1_q   <= '0;
            end
            if (accept) begin
                if (in_window) begin
                    index_q <= index_q + 1'b1;
                end else begin
                    overflow_q <= 1'b1;
                end
                if (search && hit) begin
                    found_q  <= 1'b1;
                    index0_q <= hm_read_value[INDEX_WIDTH-1:0];
                    index1_q <= index_q[INDEX_WIDTH-1:0];
                end
            end
        end
    end

    assign out_found    = found_q;
    assign out_index0   = index0_q;
    assign out_index1   = index1_q;
    assign out_overflow = overflow_q;

endmodule

// File: tb/tb_two_sum_ctrl.sv
// Bench for two_sum_ctrl with a 4-slot direct-mapped hashmap model
// (slot = key[1:0], no tag check in the map itself).

module tb_two_sum_ctrl;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int VW = DW + IW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] target;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_found;
    logic [IW-1:0] out_index0;
    logic [IW-1:0] out_index1;
    logic          out_overflow;
    logic [DW-1:0] hm_write_key;
    logic [VW-1:0] hm_write_value;
    logic          hm_write_request;
    logic [DW-1:0] hm_read_key;
    logic [VW-1:0] hm_read_value;
    logic          hm_read_response;
    logic          hm_clear;

    int n_cmp = 0;
    int n_err = 0;
    int excl_viol = 0;

    always #5 clk = ~clk;

    two_sum_ctrl #(
        .DATA_WIDTH (DW),
        .INDEX_WIDTH(IW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .target          (target),
        .busy            (busy),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_last         (in_last),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_found       (out_found),
        .out_index0      (out_index0),
        .out_index1      (out_index1),
        .out_overflow    (out_overflow),
        .hm_write_key    (hm_write_key),
        .hm_write_value  (hm_write_value),
        .hm_write_request(hm_write_request),
        .hm_read_key     (hm_read_key),
        .hm_read_value   (hm_read_value),
        .hm_read_response(hm_read_response),
        .hm_clear        (hm_clear)
    );

    // Hashmap model: combinational read, write/clear at the clock edge.
    logic          hm_vld [4];
    logic [VW-1:0] hm_mem [4];

    assign hm_read_response = hm_vld[hm_read_key[1:0]];
    assign hm_read_value    = hm_mem[hm_read_key[1:0]];

    always @(posedge clk) begin
        if (hm_write_request && hm_clear) excl_viol <= excl_viol + 1;
        if (rst || hm_clear) begin
            for (int i = 0; i < 4; i++) begin
                hm_vld[i] <= 1'b0;
                hm_mem[i] <= '0;
            end
        end else if (hm_write_request) begin
            hm_vld[hm_write_key[1:0]] <= 1'b1;
            hm_mem[hm_write_key[1:0]] <= hm_write_value;
        end
    end

    typedef struct {
        logic [DW-1:0] tgt;
        int            len;
        logic [DW-1:0] el [20];
        bit            gaps;
        int            hold;
        bit            found;
        int            i0;
        int            i1;
        bit            ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_problem(input vec_t v);
        int w;
        start  = 1'b1;
        target = v.tgt;
        step();
        start  = 1'b0;
        // CLEAR cycle: map is being cleared, no element taken yet.
        chk("clear_busy", int'(busy), 1);
        chk("clear_in_ready", int'(in_ready), 0);
        chk("clear_hm_clear", int'(hm_clear), 1);
        step();
        chk("run_in_ready", int'(in_ready), 1);
        chk("run_hm_clear", int'(hm_clear), 0);
        for (int i = 0; i < v.len; i++) begin
            in_valid = 1'b1;
            in_data  = v.el[i];
            in_last  = (i == v.len - 1);
            w = 0;
            while (!in_ready && w < 20) begin
                step();
                w++;
            end
            if (!in_ready) chk("elem_ready_timeout", int'(in_ready), 1);
            step();
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (v.gaps && i != v.len - 1) begin
                step();
                chk("gap_in_ready", int'(in_ready), 1);
            end
        end
        // Result is due the cycle after the last handshake.
        chk("done_out_valid", int'(out_valid), 1);
        chk("done_in_ready", int'(in_ready), 0);
        chk("done_found", int'(out_found), int'(v.found));
        chk("done_index0", int'(out_index0), v.i0);
        chk("done_index1", int'(out_index1), v.i1);
        chk("done_overflow", int'(out_overflow), int'(v.ovf));
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk("hold_out_valid", int'(out_valid), 1);
            chk("hold_index1", int'(out_index1), v.i1);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            vecs[k].tgt = '0; vecs[k].len = 0; vecs[k].gaps = 0; vecs[k].hold = 0;
            vecs[k].found = 0; vecs[k].i0 = 0; vecs[k].i1 = 0; vecs[k].ovf = 0;
            for (int j = 0; j < 20; j++) vecs[k].el[j] = '0;
        end
        // target 9, [2,7,11,15] -> (0,1)
        vecs[0].tgt = 8'd9; vecs[0].len = 4;
        vecs[0].el[0] = 8'd2; vecs[0].el[1] = 8'd7; vecs[0].el[2] = 8'd11; vecs[0].el[3] = 8'd15;
        vecs[0].found = 1; vecs[0].i0 = 0; vecs[0].i1 = 1;
        // target 6, [3,2,4] -> (1,2), 3 must not match itself
        vecs[1].tgt = 8'd6; vecs[1].len = 3;
        vecs[1].el[0] = 8'd3; vecs[1].el[1] = 8'd2; vecs[1].el[2] = 8'd4;
        vecs[1].found = 1; vecs[1].i0 = 1; vecs[1].i1 = 2;
        // target 6, [3,3] -> (0,1)
        vecs[2].tgt = 8'd6; vecs[2].len = 2;
        vecs[2].el[0] = 8'd3; vecs[2].el[1] = 8'd3;
        vecs[2].found = 1; vecs[2].i0 = 0; vecs[2].i1 = 1;
        // target 10, [5,1]: complement 9 shares slot 1 with key 5 -> rejected
        vecs[3].tgt = 8'd10; vecs[3].len = 2;
        vecs[3].el[0] = 8'd5; vecs[3].el[1] = 8'd1;
        // target 0, [-128,-128] with gaps and a 5-cycle result hold -> (0,1)
        vecs[4].tgt = 8'd0; vecs[4].len = 2; vecs[4].gaps = 1; vecs[4].hold = 5;
        vecs[4].el[0] = 8'h80; vecs[4].el[1] = 8'h80;
        vecs[4].found = 1; vecs[4].i0 = 0; vecs[4].i1 = 1;
        // target 100, [1..16]: exactly full length, no pair, no overflow
        vecs[5].tgt = 8'd100; vecs[5].len = 16;
        for (int j = 0; j < 16; j++) vecs[5].el[j] = 8'(j + 1);
        // target 100, [1..16, 84]: 84 would hit key 16 but sits past the window
        vecs[6].tgt = 8'd100; vecs[6].len = 17; vecs[6].ovf = 1;
        for (int j = 0; j < 16; j++) vecs[6].el[j] = 8'(j + 1);
        vecs[6].el[16] = 8'd84;
        // after mid-run reset: target 3, [1,2] -> (0,1)
        vecs[7].tgt = 8'd3; vecs[7].len = 2;
        vecs[7].el[0] = 8'd1; vecs[7].el[1] = 8'd2;
        vecs[7].found = 1; vecs[7].i0 = 0; vecs[7].i1 = 1;

        rst = 1'b1; start = 1'b0; target = '0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_found", int'(out_found), 0);
        chk("rst_out_overflow", int'(out_overflow), 0);
        chk("rst_out_index0", int'(out_index0), 0);
        chk("rst_out_index1", int'(out_index1), 0);
        chk("rst_hm_clear", int'(hm_clear), 0);
        chk("rst_hm_write", int'(hm_write_request), 0);

        for (int k = 0; k < 7; k++) run_problem(vecs[k]);

        // Reset mid-run: target 3, stream 2 then 5 leaves key 2 -> {2,0} in
        // slot 2, which would falsely pair with element 1 if it survived.
        start = 1'b1; target = 8'd3;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = 8'd2;
        step();
        in_data = 8'd5;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        run_problem(vecs[7]);

        // start outside idle is ignored: raise start while result is pending.
        start = 1'b1; target = 8'd9;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1; in_data = 8'd4; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_last = 1'b0;
        chk("ign_out_valid", int'(out_valid), 1);
        start = 1'b1;
        step();
        chk("ign_start_busy", int'(busy), 1);
        chk("ign_start_valid", int'(out_valid), 1);
        start = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("ign_idle_busy", int'(busy), 0);

        chk("write_clear_exclusive", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

endmodule
